step_alu_pipe: RTL
==================

STEP_ALU_PIPE -- requirements
Module: step_alu_pipe

Interface
REQ-001 Parameter: SIZE, 5, operand width in bits; results are SIZE+1 bits.
REQ-002 Parameter: STEP, 5, unsigned offset constant; SHALL satisfy 0 < STEP < 2^SIZE.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-low (rst=0 resets on the next clk edge).
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block accepts a request this cycle.
REQ-007 Port: in1, in2  input  SIZE each  unsigned operands.
REQ-008 Port: iseq  input  1  operand select: 1 selects in2, 0 selects in1.
REQ-009 Port: op  input  2  00 SUB (operand-STEP), 01 ADD (operand+STEP), 10 ACC (acc+operand), 11 LOAD (acc:=operand).
REQ-010 Port: out_valid  output  1  res/sign/zero hold a valid result.
REQ-011 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: res  output  SIZE+1  two's-complement result.
REQ-013 Port: sign  output  1  equals res[SIZE].
REQ-014 Port: zero  output  1  1 when res is all zeros.

Function
REQ-015 Transfer on input: in_valid & in_ready; on output: out_valid & out_ready; no other event changes pipeline state.
REQ-016 Pipeline: stage S1 registers the selected operand (zero-extended to SIZE+1) and op; stage S2 computes and registers res/sign/zero.
REQ-017 Latency: exactly 2 clk edges from input transfer to out_valid=1 when no backpressure.
REQ-018 Throughput: one request per cycle when out_ready=1 continuously.
REQ-019 S2 SHALL load from S1 when S1 is valid and (S2 empty or S2 output transfer in the same cycle).
REQ-020 in_ready = !S1_valid | S2 loads from S1 this cycle; combinational from out_ready allowed, from in_valid forbidden.
REQ-021 out_valid, once 1, SHALL stay 1 with res/sign/zero stable until an output transfer.
REQ-022 SUB/ADD: res = operand -/+ STEP modulo 2^(SIZE+1); accumulator unchanged.
REQ-023 ACC: acc := acc + operand; res = new acc value.
REQ-024 LOAD: acc := operand; res = operand.
REQ-025 Accumulator: SIZE+1-bit signed register, updated only when the ACC/LOAD request moves from S1 to S2, so back-to-back ACC requests see each preceding update.
REQ-026 Simultaneous output and input transfer with full pipeline: all stages advance, no request lost or duplicated.
REQ-027 in1/in2/iseq/op SHALL be sampled only at input transfer; later changes have no effect.

Reset
REQ-028 While rst=0 at a clk edge: S1_valid=0, out_valid=0, res=0, sign=0, zero=1, acc=0; pending requests are discarded.
REQ-029 in_ready SHALL read 1 in the first cycle after reset is released.
REQ-030 Reset asserted mid-operation SHALL take priority over any simultaneous transfer.

Configuration
REQ-031 Macro STEP_ALU_SAT_EN: when defined, ADD, SUB and ACC results saturate to the signed range [-2^SIZE, 2^SIZE-1] of SIZE+1 bits.
REQ-032 Without STEP_ALU_SAT_EN, all arithmetic wraps modulo 2^(SIZE+1); saturation logic SHALL be absent.

Verification (SIZE=5, STEP=5)
REQ-033 SUB, iseq=0, in1=3 -> after 2 edges res=6'b111110, sign=1, zero=0.
REQ-034 ADD, iseq=1, in1=0, in2=31 -> res=6'b100100 (36, wrap build), sign=1; with STEP_ALU_SAT_EN res=6'b011111, sign=0.
REQ-035 LOAD 20, then ACC 20 back-to-back -> results 20 then 40 wrap build (6'b101000); 31 with STEP_ALU_SAT_EN.
REQ-036 out_ready=0 for 4 cycles while 3 requests are offered -> in_ready=0 after 2 accepted, res stable; release -> results emerge in order.
REQ-037 SUB, in1=5 -> res=0, zero=1, sign=0.
REQ-038 rst=0 asserted with both stages full -> next cycle out_valid=0, acc=0, zero=1; subsequent ACC 7 yields res=7.

Source files
------------

// File: rtl/step_alu_pipe.sv
// Two-stage step ALU: S1 registers the selected operand, S2 computes and holds the result.
// Optional STEP_ALU_SAT_EN makes ADD/SUB/ACC saturate to the signed SIZE+1-bit range.
module step_alu_pipe #(
  parameter int unsigned SIZE = 5,
  parameter int unsigned STEP = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  input  logic            iseq,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE:0]   res,
  output logic            sign,
  output logic            zero
);

  typedef enum logic [1:0] {
    OpSub  = 2'b00,
    OpAdd  = 2'b01,
    OpAcc  = 2'b10,
    OpLoad = 2'b11
  } op_e;

`ifdef STEP_ALU_SAT_EN
  // One guard bit so overflow out of the SIZE+1-bit signed range is visible.
  localparam int unsigned CalcW = SIZE + 2;
`else
  localparam int unsigned CalcW = SIZE + 1;
`endif

  logic                s1_valid_q;
  logic [SIZE:0]       s1_opnd_q;
  op_e                 s1_op_q;
  logic                out_valid_q;
  logic [SIZE:0]       res_q;
  logic signed [SIZE:0] acc_q;

  logic                in_xfer;
  logic                out_xfer;
  logic                s2_load;
  logic [CalcW-1:0]    opnd_ext;
  logic [CalcW-1:0]    acc_ext;
  logic [CalcW-1:0]    step_ext;
  logic [CalcW-1:0]    calc;
  logic [SIZE:0]       res_d;

  assign out_xfer = out_valid_q & out_ready;
  assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    opnd_ext = CalcW'(s1_opnd_q);
    acc_ext  = CalcW'(acc_q);
    step_ext = CalcW'(STEP);
    calc     = '0;
    unique case (s1_op_q)
      OpSub:  calc = opnd_ext - step_ext;
      OpAdd:  calc = opnd_ext + step_ext;
      OpAcc:  calc = acc_ext + opnd_ext;
      OpLoad: calc = opnd_ext;
    endcase
`ifdef STEP_ALU_SAT_EN
    if (calc[CalcW-1] != calc[CalcW-2]) begin
      res_d = calc[CalcW-1] ? {1'b1, {SIZE{1'b0}}} : {1'b0, {SIZE{1'b1}}};
    end else begin
      res_d = calc[SIZE:0];
    end
`else
    res_d = calc;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_opnd_q   <= '0;
      s1_op_q     <= OpSub;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
    end else begin
      if (in_xfer) begin
        s1_opnd_q <= {1'b0, (iseq ? in2 : in1)};
        s1_op_q   <= op_e'(op);
      end
      if (in_xfer) begin
        s1_valid_q <= 1'b1;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_load) begin
        out_valid_q <= 1'b1;
        res_q       <= res_d;
        // Accumulator moves with the request so back-to-back ACCs chain.
        if (s1_op_q == OpAcc || s1_op_q == OpLoad) begin
          acc_q <= res_d;
        end
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign sign      = res_q[SIZE];
  assign zero      = ~|res_q;

endmodule
